// File: rtl/bsg_cache_sbuf_queue_pkg.sv
// Shared types and helpers for the store-buffer queue FIFO.
package bsg_cache_sbuf_queue_pkg;

  // Per-entry next-value source.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SHIFT   = 2'd1,
    LOAD_IN = 2'd2
  } sbuf_sel_e;

  // Occupancy counter must represent 0..els inclusive.
  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_cache_sbuf_queue_el.sv
// One store-buffer queue entry: a width_p register that holds, shifts from its
// upper neighbour, or loads the incoming word.
module bsg_cache_sbuf_queue_el
  import bsg_cache_sbuf_queue_pkg::*;
#(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         sel_i,
  input  logic [width_p-1:0] shift_data_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    case (sbuf_sel_e'(sel_i))
      SHIFT:   data_d = shift_data_i;
      LOAD_IN: data_d = data_i;
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_cache_sbuf_queue_fifo.sv
// N-entry in-order store-buffer shift queue with snoop outputs.
// Define BSG_CACHE_SBUF_QUEUE_BYPASS_EN for an empty-queue combinational bypass.
module bsg_cache_sbuf_queue_fifo
  import bsg_cache_sbuf_queue_pkg::*;
#(
  parameter  int unsigned width_p   = 32,
  parameter  int unsigned els_p     = 2,
  localparam int unsigned lg_els_lp = count_width(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [els_p-1:0]           snoop_v_o,
  output logic [els_p*width_p-1:0]   snoop_data_o,
  output logic [lg_els_lp-1:0]       count_o
);

  logic [lg_els_lp-1:0] count_q, count_d;
  logic [width_p-1:0]   entry [els_p];
  logic [1:0]           sel   [els_p];
  logic                 empty, enq, deq;

  assign empty   = (count_q == '0);
  assign ready_o = (count_q != lg_els_lp'(els_p));
  // A dequeue from an empty queue is illegal; gating keeps the count sane.
  assign deq     = yumi_i & ~empty;

`ifdef BSG_CACHE_SBUF_QUEUE_BYPASS_EN
  logic pass;
  // Word consumed in the same cycle it arrives at an empty queue: never stored.
  assign pass   = empty & v_i & yumi_i;
  assign enq    = v_i & ready_o & ~pass;
  assign v_o    = empty ? v_i : 1'b1;
  assign data_o = empty ? data_i : entry[0];
`else
  assign enq    = v_i & ready_o;
  assign v_o    = ~empty;
  assign data_o = entry[0];
`endif

  always_comb begin
    count_d = count_q;
    if (enq && !deq)      count_d = count_q + lg_els_lp'(1);
    else if (deq && !enq) count_d = count_q - lg_els_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  always_comb begin
    for (int unsigned i = 0; i < els_p; i++) begin
      sel[i] = HOLD;
      if (enq && deq) begin
        if (lg_els_lp'(i) == count_q - lg_els_lp'(1)) sel[i] = LOAD_IN;
        else if (i < els_p - 1)                       sel[i] = SHIFT;
      end else if (deq) begin
        if (i < els_p - 1) sel[i] = SHIFT;
      end else if (enq) begin
        if (lg_els_lp'(i) == count_q) sel[i] = LOAD_IN;
      end
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_el
    logic [width_p-1:0] upper;
    if (i < els_p - 1) begin : g_mid
      assign upper = entry[i+1];
    end else begin : g_top
      assign upper = entry[i];
    end

    bsg_cache_sbuf_queue_el #(
      .width_p(width_p)
    ) u_el (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .sel_i       (sel[i]),
      .shift_data_i(upper),
      .data_i      (data_i),
      .data_o      (entry[i])
    );

    assign snoop_v_o[i]                      = (lg_els_lp'(i) < count_q);
    assign snoop_data_o[i*width_p +: width_p] = entry[i];
  end

  assign count_o = count_q;

`ifndef SYNTHESIS
  a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");
  a_count_bound : assert property (@(posedge clk_i) disable iff (reset_i)
    count_q <= lg_els_lp'(els_p))
    else $error("count exceeded els_p");
  a_full_ignore : assert property (@(posedge clk_i) disable iff (reset_i)
    (v_i && !ready_o && !yumi_i) |=> $stable(count_q))
    else $error("enqueue into full queue changed state");
`endif

endmodule
